// File: rtl/cond_pkg.sv
// Shared definitions for the execute-stage condition unit:
// condition codes, flag bit positions, flag write group geometry and IT sequencer state.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Largest IT block the state struct can describe.
    localparam int IT_LIMIT = 4;

    // Group g of ngrp covers flag bits [grp_lo + grp_width - 1 : grp_lo].
    function automatic int grp_width(input int ngrp);
        return 4 / ngrp;
    endfunction

    function automatic int grp_lo(input int g, input int ngrp);
        return (g * 4) / ngrp;
    endfunction

    // len == 0 means the sequencer is idle.
    typedef struct packed {
        logic [2:0] len;
        logic [2:0] slot;
        logic [3:0] cond;
        logic [3:0] then_mask;
    } it_state_t;

endpackage

// File: rtl/cond_unit_it_if.sv
// E-stage bus between decode/hazard control (master) and the condition unit (slave).
interface cond_unit_it_if #(
    parameter int NCTX  = 2,
    parameter int NGRP  = 2,
    parameter int ITMAX = 4
) ();

    localparam int CW = (NCTX > 1) ? $clog2(NCTX) : 1;

    logic                ValidE;
    logic                StallE;
    logic                FlushE;
    logic [CW-1:0]       CtxE;
    logic [3:0]          CondE;
    logic [NGRP-1:0]     FlagWriteE;
    logic [3:0]          ALUFlags;
    logic                ITStartE;
    logic [3:0]          ITCondE;
    logic [2:0]          ITLenE;
    logic [ITMAX-1:0]    ITThenE;
    logic [3:0]          FlagsE;
    logic                CondExE;
    logic                ITActiveE;
    logic [3:0]          EffCondE;
    logic [4*NCTX-1:0]   FlagsAll;

    modport master (
        output ValidE, StallE, FlushE, CtxE, CondE, FlagWriteE, ALUFlags,
               ITStartE, ITCondE, ITLenE, ITThenE,
        input  FlagsE, CondExE, ITActiveE, EffCondE, FlagsAll
    );

    modport slave (
        input  ValidE, StallE, FlushE, CtxE, CondE, FlagWriteE, ALUFlags,
               ITStartE, ITCondE, ITLenE, ITThenE,
        output FlagsE, CondExE, ITActiveE, EffCondE, FlagsAll
    );

endinterface

// File: rtl/cond_unit_it_prims.sv
// Leaf blocks of the condition unit: ARM condition evaluator and an
// enabled register with synchronous reset used for flag group storage.
module condcheck
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic neg, zero, carry, ovf, ge;

    assign neg   = Flags[FLAG_N];
    assign zero  = Flags[FLAG_Z];
    assign carry = Flags[FLAG_C];
    assign ovf   = Flags[FLAG_V];
    assign ge    = (neg == ovf);

    // NV is treated as never-execute rather than unpredictable.
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = zero;
            COND_NE: CondEx = ~zero;
            COND_CS: CondEx = carry;
            COND_CC: CondEx = ~carry;
            COND_MI: CondEx = neg;
            COND_PL: CondEx = ~neg;
            COND_VS: CondEx = ovf;
            COND_VC: CondEx = ~ovf;
            COND_HI: CondEx = carry & ~zero;
            COND_LS: CondEx = ~(carry & ~zero);
            COND_GE: CondEx = ge;
            COND_LT: CondEx = ~ge;
            COND_GT: CondEx = ~zero & ge;
            COND_LE: CondEx = ~(~zero & ge);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

module flopenr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d, data_q;

    always_comb begin
        data_d = en ? d : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/cond_unit_it.sv
// E-stage condition unit: per-context NZCV flags with group writes, condition
// evaluation and a per-context IT-block sequencer honouring stall and flush.
module cond_unit_it
    import cond_pkg::*;
#(
    parameter int NCTX  = 2,
    parameter int NGRP  = 2,
    parameter int ITMAX = 4
) (
    input logic            clk,
    input logic            reset,
    cond_unit_it_if.slave  bus
);

    localparam int CW = (NCTX > 1) ? $clog2(NCTX) : 1;
    localparam int GW = grp_width(NGRP);

    logic [4*NCTX-1:0] flags_all;
    logic              ctx_ok;
    logic              live;
    logic              cc_pass;
    logic              cond_ex;
    logic              it_active;
    logic [3:0]        flags_sel;
    logic [3:0]        eff_cond;
    logic [2:0]        len_load;
    logic [3:0]        then_load;
    it_state_t         it_sel;
    it_state_t         it_d [NCTX];
    it_state_t         it_q [NCTX];

    assign ctx_ok = (int'({1'b0, bus.CtxE}) < NCTX);
    assign live   = bus.ValidE & ~bus.StallE & ~bus.FlushE & ctx_ok;

    // An out-of-range context sees zero flags and an idle sequencer.
    always_comb begin
        flags_sel = '0;
        it_sel    = '0;
        for (int k = 0; k < NCTX; k++) begin
            if (ctx_ok && (bus.CtxE == CW'(k))) begin
                flags_sel = flags_all[4*k +: 4];
                it_sel    = it_q[k];
            end
        end
    end

    assign it_active = (it_sel.len != 3'd0);

    // Else-slots flip the low bit of the base condition; AL has no inverse.
    always_comb begin
        eff_cond = bus.CondE;
        if (bus.ITStartE) begin
            eff_cond = COND_AL;
        end else if (it_active) begin
            eff_cond = it_sel.cond;
            if (!it_sel.then_mask[it_sel.slot[1:0]] && (it_sel.cond != COND_AL)) begin
                eff_cond[0] = ~it_sel.cond[0];
            end
        end
    end

    condcheck u_condcheck (
        .Cond   (eff_cond),
        .Flags  (flags_sel),
        .CondEx (cc_pass)
    );

    assign cond_ex = bus.ValidE & ~bus.FlushE & ctx_ok & cc_pass;

    genvar k, g;
    generate
        for (k = 0; k < NCTX; k++) begin : g_ctx
            for (g = 0; g < NGRP; g++) begin : g_grp
                localparam int LO = grp_lo(g, NGRP);
                logic wr_en;

                assign wr_en = live & cond_ex & bus.FlagWriteE[g] & ~bus.ITStartE
                             & (bus.CtxE == CW'(k));

                flopenr #(.WIDTH(GW)) u_flags (
                    .clk   (clk),
                    .reset (reset),
                    .en    (wr_en),
                    .d     (bus.ALUFlags[LO +: GW]),
                    .q     (flags_all[4*k + LO +: GW])
                );
            end
        end
    endgenerate

    always_comb begin
        if (bus.ITLenE == 3'd0)               len_load = 3'd1;
        else if (int'(bus.ITLenE) > ITMAX)    len_load = 3'(ITMAX);
        else                                  len_load = bus.ITLenE;
        then_load = 4'(bus.ITThenE) | 4'b0001;
    end

    // Only live instructions of the owning context move its sequencer.
    always_comb begin
        for (int c = 0; c < NCTX; c++) begin
            it_d[c] = it_q[c];
            if (live && (bus.CtxE == CW'(c))) begin
                if (bus.ITStartE) begin
                    it_d[c].len       = len_load;
                    it_d[c].slot      = 3'd0;
                    it_d[c].cond      = bus.ITCondE;
                    it_d[c].then_mask = then_load;
                end else if (it_q[c].len != 3'd0) begin
                    if (it_q[c].slot == (it_q[c].len - 3'd1)) it_d[c] = '0;
                    else it_d[c].slot = it_q[c].slot + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCTX; c++) it_q[c] <= '0;
        end else begin
            for (int c = 0; c < NCTX; c++) it_q[c] <= it_d[c];
        end
    end

    assign bus.FlagsE    = flags_sel;
    assign bus.CondExE   = cond_ex;
    assign bus.ITActiveE = it_active;
    assign bus.EffCondE  = eff_cond;
    assign bus.FlagsAll  = flags_all;

endmodule

// File: tb/tb_cond_unit_it.sv
// Directed bench for cond_unit_it: flags, group writes, condition table,
// IT sequencing with stall/flush, length bounds and context isolation.
module tb_cond_unit_it;
    import cond_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    cond_unit_it_if #(.NCTX(2), .NGRP(2), .ITMAX(4)) bus ();

    cond_unit_it #(.NCTX(2), .NGRP(2), .ITMAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic v, input logic s, input logic f, input logic ctx,
                                  input logic [3:0] cond, input logic [1:0] fw, input logic [3:0] alu,
                                  input logic its, input logic [3:0] itc, input logic [2:0] itl,
                                  input logic [3:0] itt);
        bus.ValidE = v;  bus.StallE = s;  bus.FlushE = f;  bus.CtxE = ctx;
        bus.CondE = cond; bus.FlagWriteE = fw; bus.ALUFlags = alu;
        bus.ITStartE = its; bus.ITCondE = itc; bus.ITLenE = itl; bus.ITThenE = itt;
        #1;
    endtask

    task automatic instr(input logic ctx, input logic [3:0] cond, input logic [1:0] fw, input logic [3:0] alu);
        apply_stimulus(1'b1, 1'b0, 1'b0, ctx, cond, fw, alu, 1'b0, 4'h0, 3'd0, 4'h0);
    endtask

    task automatic it_start(input logic ctx, input logic [3:0] itc, input logic [2:0] itl, input logic [3:0] itt);
        apply_stimulus(1'b1, 1'b0, 1'b0, ctx, COND_AL, 2'b11, 4'hF, 1'b1, itc, itl, itt);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, COND_AL, 2'b00, 4'h0, 1'b0, 4'h0, 3'd0, 4'h0);
        tick; tick;
        reset = 1'b0;
        #1;
        checks++; if (bus.FlagsE !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", bus.FlagsE); end
        checks++; if (bus.ITActiveE !== 1'b0) begin errors++; $display("[TB] FAIL reset_itactive: got %b expected 0", bus.ITActiveE); end
        checks++; if (bus.FlagsAll !== 8'h00) begin errors++; $display("[TB] FAIL reset_flagsall: got %h expected 00", bus.FlagsAll); end
    endtask

    task automatic test_flag_write;
        instr(1'b0, COND_AL, 2'b11, 4'b0100);
        checks++; if (bus.CondExE !== 1'b1) begin errors++; $display("[TB] FAIL wr_condex: got %b expected 1", bus.CondExE); end
        tick;
        instr(1'b0, COND_EQ, 2'b00, 4'h0);
        checks++; if (bus.FlagsE !== 4'b0100) begin errors++; $display("[TB] FAIL wr_flags_ctx0: got %b expected 0100", bus.FlagsE); end
        checks++; if (bus.CondExE !== 1'b1) begin errors++; $display("[TB] FAIL wr_eq_ctx0: got %b expected 1", bus.CondExE); end
        instr(1'b1, COND_EQ, 2'b00, 4'h0);
        checks++; if (bus.FlagsE !== 4'b0000) begin errors++; $display("[TB] FAIL wr_flags_ctx1: got %b expected 0000", bus.FlagsE); end
        checks++; if (bus.CondExE !== 1'b0) begin errors++; $display("[TB] FAIL wr_eq_ctx1: got %b expected 0", bus.CondExE); end
        tick;
    endtask

    task automatic test_group_split;
        instr(1'b1, COND_AL, 2'b10, 4'b1111);
        tick;
        instr(1'b1, COND_AL, 2'b00, 4'h0);
        checks++; if (bus.FlagsE !== 4'b1100) begin errors++; $display("[TB] FAIL grp_hi: got %b expected 1100", bus.FlagsE); end
        checks++; if (bus.FlagsAll !== 8'hC4) begin errors++; $display("[TB] FAIL grp_hi_all: got %h expected c4", bus.FlagsAll); end
        instr(1'b1, COND_AL, 2'b01, 4'b1111);
        tick;
        instr(1'b1, COND_AL, 2'b00, 4'h0);
        checks++; if (bus.FlagsAll !== 8'hF4) begin errors++; $display("[TB] FAIL grp_lo_all: got %h expected f4", bus.FlagsAll); end
    endtask

    task automatic test_cond_fail;
        instr(1'b0, COND_AL, 2'b11, 4'b0010);
        tick;
        instr(1'b0, COND_EQ, 2'b11, 4'b1111);
        checks++; if (bus.CondExE !== 1'b0) begin errors++; $display("[TB] FAIL fail_condex: got %b expected 0", bus.CondExE); end
        tick;
        instr(1'b0, COND_AL, 2'b00, 4'h0);
        checks++; if (bus.FlagsE !== 4'b0010) begin errors++; $display("[TB] FAIL fail_flags: got %b expected 0010", bus.FlagsE); end
    endtask

    task automatic test_condcheck;
        logic [15:0] exp0;
        logic [15:0] exp1;
        exp0 = 16'h55A6;
        exp1 = 16'h6655;
        for (int c = 0; c < 16; c++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'(c), 2'b11, 4'h0, 1'b0, 4'h0, 3'd0, 4'h0);
            checks++; if (bus.CondExE !== exp0[c]) begin errors++; $display("[TB] FAIL cc_ctx0_cond%0d: got %b expected %b", c, bus.CondExE, exp0[c]); end
            apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'(c), 2'b11, 4'h0, 1'b0, 4'h0, 3'd0, 4'h0);
            checks++; if (bus.CondExE !== exp1[c]) begin errors++; $display("[TB] FAIL cc_ctx1_cond%0d: got %b expected %b", c, bus.CondExE, exp1[c]); end
        end
        tick;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, COND_AL, 2'b00, 4'h0, 1'b0, 4'h0, 3'd0, 4'h0);
        checks++; if (bus.CondExE !== 1'b0) begin errors++; $display("[TB] FAIL cc_invalid: got %b expected 0", bus.CondExE); end
        checks++; if (bus.FlagsAll !== 8'hF2) begin errors++; $display("[TB] FAIL cc_stall_nowrite: got %h expected f2", bus.FlagsAll); end
    endtask

    task automatic test_it_block;
        instr(1'b0, COND_AL, 2'b11, 4'b0100);
        tick;
        it_start(1'b0, COND_EQ, 3'd3, 4'b1011);
        checks++; if (bus.EffCondE !== 4'b1110) begin errors++; $display("[TB] FAIL it_start_eff: got %b expected 1110", bus.EffCondE); end
        checks++; if (bus.CondExE !== 1'b1) begin errors++; $display("[TB] FAIL it_start_condex: got %b expected 1", bus.CondExE); end
        tick;
        checks++; if (bus.FlagsE !== 4'b0100) begin errors++; $display("[TB] FAIL it_start_nowrite: got %b expected 0100", bus.FlagsE); end
        instr(1'b0, COND_AL, 2'b00, 4'h0);
        checks++; if (bus.ITActiveE !== 1'b1) begin errors++; $display("[TB] FAIL it_active: got %b expected 1", bus.ITActiveE); end
        checks++; if (bus.EffCondE !== 4'b0000) begin errors++; $display("[TB] FAIL it_s0_eff: got %b expected 0000", bus.EffCondE); end
        checks++; if (bus.CondExE !== 1'b1) begin errors++; $display("[TB] FAIL it_s0_condex: got %b expected 1", bus.CondExE); end
        tick;
        checks++; if (bus.CondExE !== 1'b1) begin errors++; $display("[TB] FAIL it_s1_condex: got %b expected 1", bus.CondExE); end
        tick;
        checks++; if (bus.EffCondE !== 4'b0001) begin errors++; $display("[TB] FAIL it_s2_eff: got %b expected 0001", bus.EffCondE); end
        checks++; if (bus.CondExE !== 1'b0) begin errors++; $display("[TB] FAIL it_s2_condex: got %b expected 0", bus.CondExE); end
        tick;
        checks++; if (bus.ITActiveE !== 1'b0) begin errors++; $display("[TB] FAIL it_end_active: got %b expected 0", bus.ITActiveE); end
        checks++; if (bus.EffCondE !== 4'b1110) begin errors++; $display("[TB] FAIL it_end_eff: got %b expected 1110", bus.EffCondE); end
    endtask

    task automatic test_stall_flush;
        it_start(1'b0, COND_EQ, 3'd3, 4'b1011);
        tick;
        instr(1'b0, COND_AL, 2'b00, 4'h0);
        tick;
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, COND_AL, 2'b00, 4'h0, 1'b0, 4'h0, 3'd0, 4'h0);
        checks++; if (bus.CondExE !== 1'b0) begin errors++; $display("[TB] FAIL flush_condex: got %b expected 0", bus.CondExE); end
        tick;
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, COND_AL, 2'b11, 4'b0000, 1'b0, 4'h0, 3'd0, 4'h0);
            checks++; if (bus.EffCondE !== 4'b0000) begin errors++; $display("[TB] FAIL stall%0d_eff: got %b expected 0000", i, bus.EffCondE); end
            checks++; if (bus.CondExE !== 1'b1) begin errors++; $display("[TB] FAIL stall%0d_condex: got %b expected 1", i, bus.CondExE); end
            tick;
        end
        checks++; if (bus.FlagsE !== 4'b0100) begin errors++; $display("[TB] FAIL stall_nowrite: got %b expected 0100", bus.FlagsE); end
        instr(1'b0, COND_AL, 2'b00, 4'h0);
        checks++; if (bus.EffCondE !== 4'b0000) begin errors++; $display("[TB] FAIL replay_eff: got %b expected 0000", bus.EffCondE); end
        tick;
        checks++; if (bus.EffCondE !== 4'b0001) begin errors++; $display("[TB] FAIL replay_s2_eff: got %b expected 0001", bus.EffCondE); end
        checks++; if (bus.ITActiveE !== 1'b1) begin errors++; $display("[TB] FAIL replay_s2_active: got %b expected 1", bus.ITActiveE); end
        tick;
        checks++; if (bus.ITActiveE !== 1'b0) begin errors++; $display("[TB] FAIL replay_end_active: got %b expected 0", bus.ITActiveE); end
    endtask

    task automatic test_it_bounds;
        it_start(1'b0, COND_NE, 3'd0, 4'b0000);
        tick;
        instr(1'b0, COND_AL, 2'b00, 4'h0);
        checks++; if (bus.EffCondE !== 4'b0001) begin errors++; $display("[TB] FAIL len0_eff: got %b expected 0001", bus.EffCondE); end
        tick;
        checks++; if (bus.ITActiveE !== 1'b0) begin errors++; $display("[TB] FAIL len0_end: got %b expected 0", bus.ITActiveE); end
        it_start(1'b0, COND_AL, 3'd7, 4'b0000);
        tick;
        instr(1'b0, COND_EQ, 2'b00, 4'h0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.ITActiveE !== 1'b1) begin errors++; $display("[TB] FAIL len7_s%0d_active: got %b expected 1", i, bus.ITActiveE); end
            checks++; if (bus.EffCondE !== 4'b1110) begin errors++; $display("[TB] FAIL len7_s%0d_eff: got %b expected 1110", i, bus.EffCondE); end
            tick;
        end
        checks++; if (bus.ITActiveE !== 1'b0) begin errors++; $display("[TB] FAIL len7_end: got %b expected 0", bus.ITActiveE); end
        it_start(1'b0, COND_EQ, 3'd2, 4'b1111);
        tick;
        instr(1'b0, COND_AL, 2'b00, 4'h0);
        tick;
        it_start(1'b0, COND_NE, 3'd1, 4'b1111);
        checks++; if (bus.CondExE !== 1'b1) begin errors++; $display("[TB] FAIL reload_condex: got %b expected 1", bus.CondExE); end
        tick;
        instr(1'b0, COND_AL, 2'b00, 4'h0);
        checks++; if (bus.EffCondE !== 4'b0001) begin errors++; $display("[TB] FAIL reload_eff: got %b expected 0001", bus.EffCondE); end
        tick;
        checks++; if (bus.ITActiveE !== 1'b0) begin errors++; $display("[TB] FAIL reload_end: got %b expected 0", bus.ITActiveE); end
    endtask

    task automatic test_ctx_isolation;
        it_start(1'b0, COND_EQ, 3'd2, 4'b0001);
        tick;
        instr(1'b1, COND_MI, 2'b00, 4'h0);
        checks++; if (bus.ITActiveE !== 1'b0) begin errors++; $display("[TB] FAIL iso_ctx1_active: got %b expected 0", bus.ITActiveE); end
        checks++; if (bus.EffCondE !== 4'b0100) begin errors++; $display("[TB] FAIL iso_ctx1_eff: got %b expected 0100", bus.EffCondE); end
        checks++; if (bus.CondExE !== 1'b1) begin errors++; $display("[TB] FAIL iso_ctx1_mi: got %b expected 1", bus.CondExE); end
        tick;
        instr(1'b0, COND_AL, 2'b00, 4'h0);
        checks++; if (bus.EffCondE !== 4'b0000) begin errors++; $display("[TB] FAIL iso_ctx0_s0: got %b expected 0000", bus.EffCondE); end
        tick;
        instr(1'b1, COND_PL, 2'b00, 4'h0);
        checks++; if (bus.CondExE !== 1'b0) begin errors++; $display("[TB] FAIL iso_ctx1_pl: got %b expected 0", bus.CondExE); end
        tick;
        instr(1'b0, COND_AL, 2'b00, 4'h0);
        checks++; if (bus.EffCondE !== 4'b0001) begin errors++; $display("[TB] FAIL iso_ctx0_s1: got %b expected 0001", bus.EffCondE); end
        checks++; if (bus.CondExE !== 1'b0) begin errors++; $display("[TB] FAIL iso_ctx0_s1_condex: got %b expected 0", bus.CondExE); end
        tick;
        checks++; if (bus.ITActiveE !== 1'b0) begin errors++; $display("[TB] FAIL iso_ctx0_end: got %b expected 0", bus.ITActiveE); end
        it_start(1'b0, COND_EQ, 3'd4, 4'b1111);
        tick;
        it_start(1'b1, COND_EQ, 3'd4, 4'b1111);
        tick;
        instr(1'b0, COND_AL, 2'b00, 4'h0);
        checks++; if (bus.ITActiveE !== 1'b1) begin errors++; $display("[TB] FAIL mid_ctx0_active: got %b expected 1", bus.ITActiveE); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        checks++; if (bus.ITActiveE !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ctx0: got %b expected 0", bus.ITActiveE); end
        instr(1'b1, COND_AL, 2'b00, 4'h0);
        checks++; if (bus.ITActiveE !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ctx1: got %b expected 0", bus.ITActiveE); end
        checks++; if (bus.FlagsAll !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_flags: got %h expected 00", bus.FlagsAll); end
    endtask

    initial begin
        test_reset;
        test_flag_write;
        test_group_split;
        test_cond_fail;
        test_condcheck;
        test_it_block;
        test_stall_flush;
        test_it_bounds;
        test_ctx_isolation;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
